// File: rtl/ysyx_24120013_pkg.sv
// Shared definitions for the ysyx_24120013 core: word/address widths used by
// the PC, IFU and instruction memory, the instruction-memory base address,
// the instruction-memory responder FSM states and the LFSR step helper.
`timescale 1ns/1ps

package ysyx_24120013_pkg;

    localparam int CORE_DATA_WIDTH = 32;
    localparam int CORE_ADDR_WIDTH = 32;

    // Byte address that maps to word 0 of instruction memory
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    // One step of the 8-bit Fibonacci LFSR with taps 8,6,5,4
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/ysyx_24120013_imem_array.sv
// Instruction storage: word array with a synchronous write (load) port and a
// registered read port. The read register is only updated on rd_en, so the
// captured word stays stable while the response is held. A read and a write
// of the same word on the same edge returns the old contents.
`timescale 1ns/1ps

module ysyx_24120013_imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Load port: storage is never reset, so writes land even while rst is high
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // Registered read at the capture edge (old data on a same-edge write)
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_24120013_imem_resp.sv
// Instruction-memory responder: memory side of the fetch interface.
// One request outstanding at a time; a request accepted at edge N produces
// rsp_valid after edge N+LATENCY, and the response is held until rsp_ready.
// Optional feature macro: YSYX_24120013_IMEM_RAND_DELAY_EN adds 0..3 extra
// cycles per request from an 8-bit LFSR (seed 8'hA5).
`timescale 1ns/1ps

module ysyx_24120013_imem_resp
    import ysyx_24120013_pkg::*;
#(
    parameter int                    DATA_WIDTH = CORE_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = CORE_ADDR_WIDTH,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(IMEM_BASE_ADDR),
    parameter int                    LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [DATA_WIDTH-1:0]    load_data
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef YSYX_24120013_IMEM_RAND_DELAY_EN
    localparam int CNT_W = $clog2(LATENCY + 4);
`else
    localparam int CNT_W = $clog2(LATENCY + 1);
`endif

    imem_state_e           state_reg;
    logic                  req_ready_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_start;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  addr_err;
    logic                  accept;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rd_data;

    assign accept  = (state_reg == IDLE) && req_valid && req_ready_reg;
    assign capture = (state_reg == WAIT) && (cnt_reg == '0);

    // Address decode of the latched request
    assign offset   = addr_reg - BASE_ADDR;
    assign idx_full = offset >> 2;
    assign addr_err = (addr_reg[1:0] != 2'b00) ||
                      (addr_reg < BASE_ADDR) ||
                      (idx_full >= ADDR_WIDTH'(DEPTH));

`ifdef YSYX_24120013_IMEM_RAND_DELAY_EN
    logic [7:0] lfsr_reg;

    // Delay LFSR: steps once per accepted request; the pre-step low bits
    // give that request's extra cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= 8'hA5;
        end else if (accept) begin
            lfsr_reg <= lfsr8_next(lfsr_reg);
        end
    end

    assign cnt_start = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_reg[1:0]);
`else
    assign cnt_start = CNT_W'(LATENCY - 1);
`endif

    // Request/response FSM. The cycles between accept and capture are spent in
    // WAIT (a single cycle at LATENCY=1), so the registered array read lands
    // exactly at accept+LATENCY together with rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            addr_reg      <= '0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg      <= req_addr;
                        cnt_reg       <= cnt_start;
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        rsp_err_reg   <= addr_err;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    ysyx_24120013_imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk       (clk),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .rd_en     (capture && !addr_err),
        .rd_idx    (idx_full[IDX_W-1:0]),
        .rd_data   (rd_data)
    );

    // The array read register has no reset; data is only exposed with a
    // valid, error-free response so reset and error responses read as zero.
    assign rsp_data  = (rsp_valid_reg && !rsp_err_reg) ? rd_data : '0;
    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ysyx_24120013_imem_resp.sv
// Bench for ysyx_24120013_imem_resp: two instances (LATENCY=1 and LATENCY=3)
// share clock, reset and load port; expected responses are queued at accept
// and compared when the response appears.
`timescale 1ns/1ps

module tb_ysyx_24120013_imem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ysyx_24120013_imem_resp #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .DEPTH      (DEPTH),
            .BASE_ADDR  (32'h8000_0000),
            .LATENCY    ((gi == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_addr  (req_addr[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_data  (rsp_data[gi]),
            .rsp_err   (rsp_err[gi]),
            .load_en   (load_en),
            .load_idx  (load_idx),
            .load_data (load_data)
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  lfsr_m [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'h0000_1000);
    endfunction

    function automatic logic [31:0] model_lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return model_mem[off[11:2]];
    endfunction

    task automatic next_latency(input int d, output int l);
`ifdef YSYX_24120013_IMEM_RAND_DELAY_EN
        l = lat_of(d) + int'(lfsr_m[d][1:0]);
        lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
`else
        l = lat_of(d);
`endif
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[idx] = data;
    endtask

    // One fetch on instance d; optionally writes rbw_idx at the capture edge
    task automatic fetch(input int d, input logic [31:0] addr, input int hold,
                         input bit rbw, input logic [9:0] rbw_idx, input logic [31:0] rbw_data);
        exp_t e;
        exp_t got;
        int   n;
        bit   rdy;
        req_addr[d]  = addr;
        req_valid[d] = 1'b1;
        n = 0;
        do begin
            rdy = req_ready[d];
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        req_valid[d] = 1'b0;
        if (!rdy) begin
            check_eq("accept_timeout", 0, 1);
            return;
        end
        e.dut  = d;
        e.addr = addr;
        e.err  = addr_bad(addr);
        e.data = e.err ? 32'h0 : model_lookup(addr);
        next_latency(d, e.lat);
        sb.push_back(e);
        check_eq("req_ready_drop", 64'(req_ready[d]), 0);
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            if (rbw && n == e.lat - 1) begin
                load_en   = 1'b1;
                load_idx  = rbw_idx;
                load_data = rbw_data;
            end
            @(posedge clk); #1;
            load_en = 1'b0;
            n++;
        end
        if (rbw) model_mem[rbw_idx] = rbw_data;
        if (!rsp_valid[d]) begin
            check_eq("rsp_timeout", 0, 1);
            void'(sb.pop_back());
            return;
        end
        got = sb.pop_front();
        check_eq("latency", 64'(n), 64'(got.lat));
`ifdef YSYX_24120013_IMEM_RAND_DELAY_EN
        check_eq("lat_range", 64'((n >= lat_of(d)) && (n <= lat_of(d) + 3)), 1);
`endif
        check_eq("rsp_data", rsp_data[d], got.data);
        check_eq("rsp_err", 64'(rsp_err[d]), 64'(got.err));
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(rsp_valid[d]), 1);
            check_eq("hold_data", rsp_data[d], got.data);
            check_eq("hold_req_ready", 64'(req_ready[d]), 0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check_eq("valid_clear", 64'(rsp_valid[d]), 0);
        check_eq("ready_back", 64'(req_ready[d]), 1);
        $display("fetch dut=%0d addr=%h data=%h err=%0d lat=%0d", d, addr, got.data, got.err, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [31:0] a;
        int          d;
        rst       = 1'b1;
        load_en   = 1'b0;
        load_idx  = '0;
        load_data = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
            lfsr_m[i]    = 8'hA5;
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        // Reset values, with a load issued during reset
        @(posedge clk); #1;
        load_word(10'd0, 32'h0010_0093);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_req_ready", 64'(req_ready[i]), 0);
            check_eq("rst_rsp_valid", 64'(rsp_valid[i]), 0);
            check_eq("rst_rsp_data", rsp_data[i], 0);
            check_eq("rst_rsp_err", 64'(rsp_err[i]), 0);
        end
        rst = 1'b0;
        #1;
        check_eq("ready_before_edge", 64'(req_ready[0]), 0);
        @(posedge clk); #1;
        check_eq("ready_after_edge0", 64'(req_ready[0]), 1);
        check_eq("ready_after_edge1", 64'(req_ready[1]), 1);

        // Preload words 1..31 and the last word
        for (int i = 1; i < 32; i++) load_word(10'(i), $urandom);
        load_word(10'd5, 32'h1111_2222);
        load_word(10'd6, 32'h3333_4444);
        load_word(10'd1023, 32'h0FF0_1023);

        // rsp_ready without a response is ignored
        rsp_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_rsp_ready_valid", 64'(rsp_valid[0]), 0);
        check_eq("idle_rsp_ready_ready", 64'(req_ready[0]), 1);
        rsp_ready[0] = 1'b0;

        // Basic fetches, held response, error and boundary addresses
        fetch(0, BASE, 0, 0, '0, '0);
        fetch(1, BASE + 32'h4, 4, 0, '0, '0);
        fetch(0, 32'h8000_0002, 0, 0, '0, '0);
        fetch(1, 32'h8000_1000, 0, 0, '0, '0);
        fetch(0, 32'h7FFF_FFFC, 0, 0, '0, '0);
        fetch(1, 32'h8000_0FFC, 1, 0, '0, '0);

        // Same-edge load of the captured word returns old data, then new
        fetch(0, 32'h8000_0014, 0, 1, 10'd5, 32'hDEAD_BEEF);
        fetch(0, 32'h8000_0014, 0, 0, '0, '0);
        fetch(1, 32'h8000_0018, 0, 1, 10'd6, 32'hCAFE_F00D);
        fetch(1, 32'h8000_0018, 0, 0, '0, '0);

        // Reset while the LATENCY=3 instance is in WAIT
        req_addr[1]  = BASE + 32'h8;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check_eq("mid_accept", 64'(req_ready[1]), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(rsp_valid[1]), 0);
        check_eq("mid_rst_ready", 64'(req_ready[1]), 0);
        @(posedge clk); #1;
        load_word(10'd9, 32'h0BAD_0009);
        check_eq("mid_rst_valid2", 64'(rsp_valid[1]), 0);
        check_eq("mid_rst_ready2", 64'(req_ready[1]), 0);
        rst = 1'b0;
        lfsr_m[0] = 8'hA5;
        lfsr_m[1] = 8'hA5;
        @(posedge clk); #1;
        check_eq("post_rst_ready", 64'(req_ready[1]), 1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) seen = 1'b1;
        end
        check_eq("no_stale_rsp", 64'(seen), 0);
        fetch(1, BASE + 32'h8, 0, 0, '0, '0);
        fetch(1, BASE + 32'h24, 0, 0, '0, '0);
        fetch(0, BASE, 0, 0, '0, '0);

        // Back-to-back mixed fetches
        for (int i = 0; i < 100; i++) begin
            d = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
                1:       a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 100));
                2:       a = BASE - 32'(4 * $urandom_range(1, 100));
                default: a = BASE + 32'(4 * $urandom_range(0, 31));
            endcase
            fetch(d, a, 0, 0, '0, '0);
        end

        check_eq("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
